// File: rtl/vmem_arbiter_if.sv
// Video memory arbiter bus: scanout read, pixel write,
// clear command and single-port RAM side.
interface vmem_arbiter_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 24
);
  logic              vga_req;
  logic [ADDR_W-1:0] vga_addr;
  logic [DATA_W-1:0] vga_data;
  logic              vga_data_vld;
  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic              clr_start;
  logic [DATA_W-1:0] clr_color;
  logic              clr_busy;
  logic              clr_done;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [15:0]       stall_cnt;

  modport slave (
    input  vga_req, vga_addr,
    output vga_data, vga_data_vld,
    input  wr_valid, wr_addr, wr_data,
    output wr_ready,
    input  clr_start, clr_color,
    output clr_busy, clr_done,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output stall_cnt
  );

  modport master (
    output vga_req, vga_addr,
    input  vga_data, vga_data_vld,
    output wr_valid, wr_addr, wr_data,
    input  wr_ready,
    output clr_start, clr_color,
    input  clr_busy, clr_done,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  stall_cnt
  );
endinterface

// File: rtl/vmem_arbiter.sv
// Single-port video RAM arbiter: scanout reads beat the
// clear sweep, which beats the one-entry pixel write buffer.
module vmem_arbiter #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 24,
  parameter int DEPTH  = 524288
) (
  input  logic           clk,
  input  logic           resetn,
  vmem_arbiter_if.slave  bus
);
  typedef enum logic {
    S_IDLE,
    S_SWEEP
  } state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] w_cnt_nxt;
  logic [DATA_W-1:0] r_color;
  logic [DATA_W-1:0] w_color_nxt;
  logic              r_done;
  logic              w_done_nxt;

  logic              r_rd_vld1;
  logic              r_vld;
  logic [DATA_W-1:0] r_data;

  logic              r_buf_full;
  logic [ADDR_W-1:0] r_buf_addr;
  logic [DATA_W-1:0] r_buf_data;
  logic [15:0]       r_stall;

  logic w_sweep;
  logic w_gnt_rd;
  logic w_gnt_clr;
  logic w_gnt_wr;
  logic w_accept;

  assign w_sweep   = (r_state == S_SWEEP);
  assign w_gnt_rd  = resetn & bus.vga_req;
  assign w_gnt_clr = resetn & ~bus.vga_req & w_sweep;
  assign w_gnt_wr  = resetn & ~bus.vga_req & ~w_sweep
                   & r_buf_full;
  assign w_accept  = bus.wr_valid & ~r_buf_full;

  // RAM port mux driven straight from this cycle's grant
  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    unique case (1'b1)
      w_gnt_rd: begin
        bus.mem_en   = 1'b1;
        bus.mem_addr = bus.vga_addr;
      end
      w_gnt_clr: begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = r_cnt;
        bus.mem_wdata = r_color;
      end
      w_gnt_wr: begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = r_buf_addr;
        bus.mem_wdata = r_buf_data;
      end
      default: ;
    endcase
  end

  // Clear FSM next state: sweep only advances on free cycles
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_color_nxt = r_color;
    w_done_nxt  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.clr_start) begin
          w_state_nxt = S_SWEEP;
          w_cnt_nxt   = '0;
          w_color_nxt = bus.clr_color;
        end
      end
      S_SWEEP: begin
        if (!bus.vga_req) begin
          if (r_cnt == LAST) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_done_nxt  = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
    endcase
  end

  // Clear FSM state, sweep address, colour and done pulse
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_color <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_color <= w_color_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Scanout pipeline: RAM data lands one cycle after the read
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rd_vld1 <= 1'b0;
      r_vld     <= 1'b0;
      r_data    <= '0;
    end else begin
      r_rd_vld1 <= w_gnt_rd;
      r_vld     <= r_rd_vld1;
      if (r_rd_vld1) begin
        r_data <= bus.mem_rdata;
      end
    end
  end

  // One-entry write buffer: fill when empty, drain when granted
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_buf_full <= 1'b0;
      r_buf_addr <= '0;
      r_buf_data <= '0;
    end else if (w_gnt_wr) begin
      r_buf_full <= 1'b0;
    end else if (w_accept) begin
      r_buf_full <= 1'b1;
      r_buf_addr <= bus.wr_addr;
      r_buf_data <= bus.wr_data;
    end
  end

  // Saturating count of cycles a full buffer sits undrained
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_stall <= '0;
    end else if (r_buf_full && !w_gnt_wr &&
                 r_stall != 16'hFFFF) begin
      r_stall <= r_stall + 16'd1;
    end
  end

  assign bus.vga_data     = r_data;
  assign bus.vga_data_vld = r_vld;
  assign bus.wr_ready     = ~r_buf_full;
  assign bus.clr_busy     = w_sweep;
  assign bus.clr_done     = r_done;
  assign bus.stall_cnt    = r_stall;
endmodule

// File: tb/tb_vmem_arbiter.sv
// Directed plus randomized bench for vmem_arbiter with a
// RAM model, write monitor and abstract arbitration model.
module tb_vmem_arbiter;
  localparam int AW = 19;
  localparam int DW = 24;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic resetn = 1'b1;
  always #5 clk = ~clk;

  vmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  vmem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus)
  );

  logic [DW-1:0] ram [0:(1<<AW)-1];
  logic          ld_en = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [DW-1:0] ld_data = '0;

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  int wr_clash = 0;
  logic [AW-1:0] wl_addr [$];
  logic [DW-1:0] wl_data [$];
  int            wl_cyc  [$];

  // RAM model plus write log
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ld_en) begin
      ram[ld_addr] <= ld_data;
    end else if (bus.mem_en) begin
      if (bus.mem_we) begin
        ram[bus.mem_addr] <= bus.mem_wdata;
        wl_addr.push_back(bus.mem_addr);
        wl_data.push_back(bus.mem_wdata);
        wl_cyc.push_back(cyc);
        if (bus.vga_req) wr_clash <= wr_clash + 1;
      end else begin
        bus.mem_rdata <= ram[bus.mem_addr];
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.vga_req   = 1'b0;
    bus.vga_addr  = '0;
    bus.wr_valid  = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.clr_start = 1'b0;
    bus.clr_color = '0;
  endtask

  logic [DW-1:0] m_mem [0:31];
  logic          m_full;
  logic [4:0]    m_a;
  logic [DW-1:0] m_d;
  logic [15:0]   m_stall;
  logic [DW-1:0] m_last;
  logic          r1, r2, cur_req;
  logic [DW-1:0] d1, d2, cur_d;

  initial begin
    int base, start, busy, done, done_cyc, bad;
    idle_in();
    bus.mem_rdata = '0;
    #2;
    resetn = 1'b0;
    bus.vga_req  = 1'b1;
    bus.vga_addr = AW'(5);
    nxt();
    chk("rst_mem_en", 32'(bus.mem_en), 0);
    chk("rst_vld", 32'(bus.vga_data_vld), 0);
    chk("rst_data", 32'(bus.vga_data), 0);
    chk("rst_wr_ready", 32'(bus.wr_ready), 1);
    chk("rst_busy", 32'(bus.clr_busy), 0);
    chk("rst_done", 32'(bus.clr_done), 0);
    chk("rst_stall", 32'(bus.stall_cnt), 0);
    bus.vga_req = 1'b0;
    ld_en = 1'b1; ld_addr = AW'(5); ld_data = 24'h00FF00;
    nxt();
    ld_en = 1'b0;
    resetn = 1'b1;
    nxt();
    chk("rel_wr_ready", 32'(bus.wr_ready), 1);

    // read latency
    nxt();
    bus.vga_req = 1'b1; bus.vga_addr = AW'(5);
    #1;
    chk("rd_mem_en", 32'(bus.mem_en), 1);
    chk("rd_mem_we", 32'(bus.mem_we), 0);
    chk("rd_mem_addr", 32'(bus.mem_addr), 5);
    nxt();
    bus.vga_req = 1'b0;
    #1;
    chk("rd_vld_t1", 32'(bus.vga_data_vld), 0);
    nxt();
    chk("rd_vld_t2", 32'(bus.vga_data_vld), 1);
    chk("rd_data_t2", 32'(bus.vga_data), 32'h00FF00);
    nxt();
    chk("rd_vld_t3", 32'(bus.vga_data_vld), 0);
    chk("rd_hold_t3", 32'(bus.vga_data), 32'h00FF00);

    // write blocked by scanout, extra request ignored
    base = wl_addr.size();
    nxt();
    bus.vga_req = 1'b1; bus.vga_addr = '0;
    bus.wr_valid = 1'b1; bus.wr_addr = AW'(7);
    bus.wr_data = 24'h123456;
    #1;
    chk("prio_ready_c0", 32'(bus.wr_ready), 1);
    for (int i = 1; i < 10; i++) begin
      nxt();
      bus.wr_addr = AW'(9); bus.wr_data = 24'h0BAD00;
    end
    nxt();
    chk("prio_ready_blk", 32'(bus.wr_ready), 0);
    chk("prio_stall", 32'(bus.stall_cnt), 9);
    chk("prio_nowrite", wl_addr.size(), base);
    bus.vga_req = 1'b0; bus.wr_valid = 1'b0;
    #1;
    chk("prio_drain_we", 32'(bus.mem_we), 1);
    chk("prio_drain_addr", 32'(bus.mem_addr), 7);
    chk("prio_drain_data", 32'(bus.mem_wdata), 32'h123456);
    nxt();
    chk("prio_ready_after", 32'(bus.wr_ready), 1);
    chk("prio_one_write", wl_addr.size(), base + 1);
    chk("prio_ram7", 32'(ram[7]), 32'h123456);
    chk("prio_stall_keep", 32'(bus.stall_cnt), 9);

    // full clear with no scanout
    base = wl_addr.size();
    nxt();
    bus.clr_start = 1'b1; bus.clr_color = 24'hFFFFFF;
    start = cyc;
    #1;
    chk("clr_busy_c0", 32'(bus.clr_busy), 0);
    busy = 0; done = 0; done_cyc = -1;
    for (int i = 0; i < 40; i++) begin
      nxt();
      bus.clr_start = 1'b0;
      #1;
      if (bus.clr_busy) busy++;
      if (bus.clr_done) begin
        done++;
        done_cyc = cyc;
      end
    end
    chk("clr_busy_cycles", busy, 16);
    chk("clr_done_pulses", done, 1);
    chk("clr_nwrites", wl_addr.size(), base + 16);
    bad = 0;
    for (int k = 0; k < 16; k++) begin
      if (wl_addr[base+k] !== AW'(k) ||
          wl_data[base+k] !== 24'hFFFFFF ||
          wl_cyc[base+k] != start + 1 + k) bad++;
    end
    chk("clr_seq_bad", bad, 0);
    chk("clr_done_cyc", done_cyc, start + 17);

    // clear stalled by alternating scanout, write pending
    base = wl_addr.size();
    nxt();
    bus.clr_start = 1'b1; bus.clr_color = 24'h00A0A0;
    bus.vga_req = 1'b1;
    bus.wr_valid = 1'b1; bus.wr_addr = AW'(3);
    bus.wr_data = 24'hABCDEF;
    start = cyc;
    #1;
    chk("stl_c0_we", 32'(bus.mem_we), 0);
    busy = 0; done = 0;
    for (int i = 1; i <= 50; i++) begin
      nxt();
      bus.clr_start = 1'b0; bus.wr_valid = 1'b0;
      bus.vga_req = i[0];
      #1;
      if (bus.clr_busy) busy++;
      if (bus.clr_done) done++;
    end
    bus.vga_req = 1'b0;
    chk("stl_busy_cycles", busy, 32);
    chk("stl_done_pulses", done, 1);
    chk("stl_nwrites", wl_addr.size(), base + 17);
    bad = 0;
    for (int k = 0; k < 16; k++) begin
      if (wl_addr[base+k] !== AW'(k) ||
          wl_data[base+k] !== 24'h00A0A0) bad++;
    end
    chk("stl_seq_bad", bad, 0);
    chk("stl_last_clr_cyc", wl_cyc[base+15], start + 32);
    chk("stl_buf_addr", 32'(wl_addr[base+16]), 3);
    chk("stl_buf_data", 32'(wl_data[base+16]), 32'hABCDEF);
    chk("stl_ram3", 32'(ram[3]), 32'hABCDEF);

    // reset in the middle of a sweep
    base = wl_addr.size();
    nxt();
    bus.clr_start = 1'b1; bus.clr_color = 24'h112233;
    bus.wr_valid = 1'b1; bus.wr_addr = AW'(20);
    bus.wr_data = 24'h445566;
    for (int i = 1; i <= 9; i++) begin
      nxt();
      bus.clr_start = 1'b0; bus.wr_valid = 1'b0;
    end
    #1;
    chk("mid_pre_addr", 32'(bus.mem_addr), 8);
    chk("mid_pre_we", 32'(bus.mem_we), 1);
    resetn = 1'b0;
    #1;
    chk("mid_mem_en", 32'(bus.mem_en), 0);
    chk("mid_busy", 32'(bus.clr_busy), 0);
    chk("mid_done", 32'(bus.clr_done), 0);
    chk("mid_vld", 32'(bus.vga_data_vld), 0);
    chk("mid_data", 32'(bus.vga_data), 0);
    chk("mid_stall", 32'(bus.stall_cnt), 0);
    chk("mid_ready", 32'(bus.wr_ready), 1);
    nxt();
    nxt();
    chk("mid_nwrites_rst", wl_addr.size(), base + 8);
    resetn = 1'b1;
    repeat (5) nxt();
    chk("mid_nwrites_post", wl_addr.size(), base + 8);
    chk("mid_busy_post", 32'(bus.clr_busy), 0);
    bus.clr_start = 1'b1; bus.clr_color = 24'h778899;
    nxt();
    bus.clr_start = 1'b0;
    #1;
    chk("restart_we", 32'(bus.mem_we), 1);
    chk("restart_addr", 32'(bus.mem_addr), 0);
    chk("restart_data", 32'(bus.mem_wdata), 32'h778899);
    repeat (20) nxt();
    chk("restart_idle", 32'(bus.clr_busy), 0);

    // randomized reads and writes against an abstract model
    resetn = 1'b0;
    nxt();
    resetn = 1'b1;
    for (int a = 0; a < 32; a++) begin
      nxt();
      ld_en = 1'b1;
      ld_addr = AW'(a);
      ld_data = DW'($urandom);
      m_mem[a] = ld_data;
    end
    nxt();
    ld_en = 1'b0;
    m_full = 1'b0; m_a = '0; m_d = '0;
    m_stall = '0; m_last = '0;
    r1 = 1'b0; r2 = 1'b0; d1 = '0; d2 = '0;
    for (int i = 0; i < 400; i++) begin
      nxt();
      bus.vga_req  = 1'($urandom_range(0, 1));
      bus.vga_addr = AW'($urandom_range(0, 31));
      bus.wr_valid = 1'($urandom_range(0, 1));
      bus.wr_addr  = AW'($urandom_range(0, 31));
      bus.wr_data  = DW'($urandom);
      #1;
      chk("rnd_ready", 32'(bus.wr_ready), 32'(!m_full));
      if (bus.vga_req) begin
        chk("rnd_rd_en", 32'(bus.mem_en), 1);
        chk("rnd_rd_we", 32'(bus.mem_we), 0);
        chk("rnd_rd_addr", 32'(bus.mem_addr),
            32'(bus.vga_addr));
      end else if (m_full) begin
        chk("rnd_wr_en", 32'(bus.mem_en), 1);
        chk("rnd_wr_we", 32'(bus.mem_we), 1);
        chk("rnd_wr_addr", 32'(bus.mem_addr), 32'(m_a));
        chk("rnd_wr_data", 32'(bus.mem_wdata), 32'(m_d));
      end else begin
        chk("rnd_idle_en", 32'(bus.mem_en), 0);
      end
      chk("rnd_vld", 32'(bus.vga_data_vld), 32'(r2));
      if (r2) begin
        chk("rnd_data", 32'(bus.vga_data), 32'(d2));
        m_last = d2;
      end else begin
        chk("rnd_hold", 32'(bus.vga_data), 32'(m_last));
      end
      chk("rnd_stall", 32'(bus.stall_cnt), 32'(m_stall));
      cur_req = bus.vga_req;
      cur_d = m_mem[bus.vga_addr[4:0]];
      if (!bus.vga_req && m_full) begin
        m_mem[m_a] = m_d;
        m_full = 1'b0;
      end else if (m_full) begin
        if (m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
      end else if (bus.wr_valid) begin
        m_full = 1'b1;
        m_a = bus.wr_addr[4:0];
        m_d = bus.wr_data;
      end
      r2 = r1; d2 = d1;
      r1 = cur_req; d1 = cur_d;
    end
    nxt();
    chk("no_write_under_read", wr_clash, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
